// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and the
// carry preset that turns a + ~b into a - b.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic CARRY_INIT_SUB = 1'b1;

endpackage

// File: rtl/serial_subtractor_fa.sv
// One-bit full-adder cell; the serial datapath reuses this single cell for every bit.
module serial_subtractor_fa (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);

  assign s_o  = a_i ^ b_i ^ ci_i;
  assign co_o = (a_i & b_i) | (a_i & ci_i) | (b_i & ci_i);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, LSB first, one bit per
// clock through one full-adder cell and a carry flop, valid/ready on both sides.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d;

  logic             fa_s, fa_co;
  logic [WIDTH-1:0] res_shift;
  logic             last_bit;

  // Subtrahend bit is inverted into the cell; carry flop supplies the +1 on bit 0.
  serial_subtractor_fa u_fa (
    .a_i  (a_sh_q[0]),
    .b_i  (~b_sh_q[0]),
    .ci_i (carry_q),
    .s_o  (fa_s),
    .co_o (fa_co)
  );

  generate
    if (WIDTH == 1) begin : g_res_w1
      assign res_shift = fa_s;
    end else begin : g_res_wn
      assign res_shift = {fa_s, res_q[WIDTH-1:1]};
    end
  endgenerate

  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          res_d   = '0;
          cnt_d   = '0;
          carry_d = CARRY_INIT_SUB;
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        res_d   = res_shift;
        carry_d = fa_co;
        cnt_d   = cnt_q + 1'b1;
        if (last_bit) begin
          state_d  = ST_DONE;
          diff_d   = res_shift;
          borrow_d = ~fa_co;
          // Overflow only when operand signs differ and the result sign leaves a's sign.
          ovf_d    = (a_msb_q != b_msb_q) && (fa_s != a_msb_q);
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_SHIFT);
  assign diff      = diff_q;
  assign borrow    = borrow_q;
  assign ovf       = ovf_q;

endmodule
